// File: rtl/regfile_if.sv
// Operand-read and write-back port bundle of the GPR file.
// The master side is the pipeline (decode and write-back). The slave side is the register file.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile.sv
// MIPS general-purpose register file: one write port and two combinational read ports.
// Register $0 is hardwired to zero. A same-cycle write is bypassed to the read ports.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic       clk,
  input logic       rst,
  regfile_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // A write issued in the same cycle as reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we && (bus.waddr != ZERO_ADDR)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    bus.rdata1 = '0;
    if (!rst && (bus.raddr1 != ZERO_ADDR) && bus.re1) begin
      if (bus.we && (bus.waddr == bus.raddr1)) begin
        bus.rdata1 = bus.wdata;
      end else begin
        bus.rdata1 = regs[bus.raddr1];
      end
    end
  end

  always_comb begin
    bus.rdata2 = '0;
    if (!rst && (bus.raddr2 != ZERO_ADDR) && bus.re2) begin
      if (bus.we && (bus.waddr == bus.raddr2)) begin
        bus.rdata2 = bus.wdata;
      end else begin
        bus.rdata2 = regs[bus.raddr2];
      end
    end
  end

endmodule
